i2s_tx: RTL
===========

# i2s_tx

I2S master transmitter. It serializes PCM samples from an upstream valid/ready stream (normally the TX sample FIFO filled over the bus) onto `sdo`, and generates `sck` and `ws` itself. It is the transmit counterpart of the I2S receive path and shares its control-field encoding (`sample_size`, `channels`, `left_justified`, `sck_prescaler`), so both can be driven from one register bank.

## Interface
- No parameters.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: enable. When 0, all sequential state freezes.
- `sck_prescaler` in 8: SCK half-period = `sck_prescaler`+1 clk cycles.
- `sample_size` in 5: bits per sample, N. Value 0 means N=32.
- `left_justified` in 1: 1 = left-justified (MSB in slot bit 0); 0 = Philips I2S (MSB in slot bit 1).
- `channels` in 2: 10 = left only, 01 = right only, 11 = stereo.
- `s_tdata` in 32: sample, right-aligned in bits [N-1:0]. Upper bits are ignored.
- `s_tvalid` in 1: upstream has a sample.
- `s_tready` out 1: one-cycle pulse; the sample is consumed when `s_tvalid && s_tready`.
- `sck` out 1: serial clock, registered.
- `ws` out 1: word select, registered. 0 = left slot, 1 = right slot.
- `sdo` out 1: serial data, registered.
- `underrun` out 1: one-cycle pulse when a slot is loaded with no sample available.

## Operation
- Prescaler:
  - 8-bit down-counter, reset 0, advances only when `en`=1.
  - At 0 it reloads `sck_prescaler`; otherwise it decrements.
  - Tick T = `en` && prescaler==0.
- SCK: toggles on every T.
  - Falling event F = T && `sck`==1.
  - All data and `ws` changes happen on F, so the receiver samples on the rising edge.
- Frame:
  - `bit_ctr`, 5-bit, reset 0, increments on F and wraps 31→0.
  - On F with `bit_ctr`==31, `ws` toggles.
  - Each slot is 32 SCK; each frame is 64 SCK.
- Load event L:
  - left_justified=1: L = F && `bit_ctr`==31. The target slot is the new `ws` (!`ws`).
  - left_justified=0: L = F && `bit_ctr`==0. The target slot is the current `ws`.
  - In I2S mode a 32-bit sample's LSB lands in bit 0 of the following slot. This is required behaviour.
- Target enabled:
  - Left slot (target `ws`=0) is enabled when `channels[1]`=1.
  - Right slot (target `ws`=1) is enabled when `channels[0]`=1.
- `s_tready` = L && target enabled. It is combinational from registered state.
- Aligned word A:
  - A = `s_tdata` << (32−N), truncated to 32 bits, when target enabled && `s_tvalid`.
  - A = 0 otherwise.
  - `underrun` = L && target enabled && !`s_tvalid`.
- Shifter (32-bit, reset 0):
  - On L: `sdo` ← A[31], shreg ← A<<1.
  - On other F: `sdo` ← shreg[31], shreg ← shreg<<1, zero-filled.
  - Bits after the N-th are 0. A disabled slot transmits all zeros and consumes nothing.
- Stereo consumption order is left, right, left, … Upstream supplies interleaved L/R words.
- Config inputs may change at any time. They take effect at the next T/L, with no glitch-protection beyond that.

## Timing
- Reset values: `sck`=0, `ws`=1, `sdo`=0, `s_tready`=0, `underrun`=0, `bit_ctr`=0, prescaler=0, shreg=0.
- First `en`=1 cycle after reset:
  - T occurs with `sck` 0→1 (rising), and the prescaler loads P.
  - The first F comes P+1 cycles later.
- Slot after reset:
  - I2S mode: the first F is an L targeting the right slot (`ws`=1).
  - LJ mode: the first L is the 32nd F; `ws` goes to 0 and the left slot is loaded.
- SCK period = 2(P+1) clk. The minimum is 2 clk (P=0).
- `sdo` and `ws` update in the same clk as the `sck` falling edge.
- The sample is accepted in the L cycle and its MSB appears on `sdo` at the end of that cycle. Load latency is 0 relative to L.
- `en` deasserted mid-frame freezes `sck`, `ws`, `sdo`, counters and shreg. Re-enabling resumes exactly where it stopped, and no `s_tready` is issued while `en`=0.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). A partially sent sample is lost.
- `s_tvalid` rising in a non-L cycle has no effect until the next L.

## Test plan
- Reset/clock: P=1, `en`=1 → `sck` period 4 clk, 50% duty. `ws` toggles every 32 SCK falling edges; first toggle on the 32nd falling edge to 0.
- LJ stereo: N=16 (`sample_size`=16), `channels`=11, push 0x0000ABCD then 0x00001234 → left slot `sdo` bits 0–15 = 0xABCD MSB-first with bits 16–31 = 0; right slot = 0x1234 likewise; exactly two `s_tready` pulses per frame.
- I2S 32-bit: `left_justified`=0, `sample_size`=0, push 0x80000001 → first slot bit 0 = previous LSB (0), bit 1 = 1, bits 2–31 = 0, LSB 1 in next slot bit 0.
- Mono left: `channels`=10, N=24, stream 0x00FFFFFF → left slot has 24 ones then 8 zeros; right slot all zeros; `s_tready` once per frame, only for the left slot.
- Underrun: stereo, `s_tvalid`=0 → `underrun` pulses at each L (twice per frame), `sdo` stays 0, no data consumed. Assert `s_tvalid` mid-slot → accepted at the next L only.
- Freeze/reset: deassert `en` for 20 cycles mid-slot → outputs stable, no `s_tready`, bit sequence continues unbroken after re-enable. Assert `rst_n`=0 mid-slot → `sck`=0, `ws`=1, `sdo`=0 in the same cycle.

Source files
------------

// File: rtl/i2s_tx_if.sv
// Sample stream into the I2S transmitter: valid/ready, one 32-bit PCM word per beat.
interface i2s_tx_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, tvalid, input tready);
  modport slave  (input tdata, tvalid, output tready);
endinterface

// File: rtl/i2s_tx.sv
// I2S master transmitter: generates sck/ws and shifts PCM words out on sdo,
// MSB first, with data and ws changing on the sck falling edge.
module i2s_tx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] sck_prescaler,
  input  logic [4:0] sample_size,
  input  logic       left_justified,
  input  logic [1:0] channels,
  i2s_tx_if.slave    s,
  output logic       sck,
  output logic       ws,
  output logic       sdo,
  output logic       underrun
);

  logic [7:0]  presc;
  logic [4:0]  bit_ctr;
  logic [31:0] shreg;

  logic        tick;
  logic        fall;
  logic        load;
  logic        tgt_ws;
  logic        tgt_en;
  logic [4:0]  shamt;
  logic [31:0] aligned;

  // Event decode, slot targeting and MSB alignment of the incoming sample.
  always_comb begin
    tick    = en && (presc == 8'd0);
    fall    = tick && sck;
    // LJ loads on the edge that starts the new slot; I2S one bit later,
    // while ws already shows the slot being filled.
    load    = fall && (left_justified ? (bit_ctr == 5'd31) : (bit_ctr == 5'd0));
    tgt_ws  = left_justified ? ~ws : ws;
    tgt_en  = tgt_ws ? channels[0] : channels[1];
    // 32-N modulo 32; sample_size==0 encodes N=32 and gives a shift of 0.
    shamt   = 5'd0 - sample_size;
    aligned = (tgt_en && s.tvalid) ? (s.tdata << shamt) : 32'd0;
    s.tready = load && tgt_en;
    underrun = load && tgt_en && !s.tvalid;
  end

  // Prescaler and serial clock; everything holds while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= 8'd0;
      sck   <= 1'b0;
    end else if (en) begin
      presc <= (presc == 8'd0) ? sck_prescaler : presc - 8'd1;
      if (tick) sck <= ~sck;
    end
  end

  // Frame position, word select and data shifter, all advanced on sck fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_ctr <= 5'd0;
      ws      <= 1'b1;
      sdo     <= 1'b0;
      shreg   <= 32'd0;
    end else if (fall) begin
      bit_ctr <= bit_ctr + 5'd1;
      if (bit_ctr == 5'd31) ws <= ~ws;
      if (load) begin
        sdo   <= aligned[31];
        shreg <= {aligned[30:0], 1'b0};
      end else begin
        sdo   <= shreg[31];
        shreg <= {shreg[30:0], 1'b0};
      end
    end
  end

endmodule
